uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arb_pkg.sv | 26 ++
 rtl/uart_rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types and constants for the UART TX arbiter
// Contents: FSM state encoding, default parameter values, byte/index widths,
// and the wrapped round-robin pointer increment helper.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_LO  = 2'd2,
    WAIT_RDY = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_TIMEOUT  = 4096;
  localparam int DEF_LOCK_MAX = 16;

  // Width of one requester data slice and of the requester index.
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  // Index following g in a ring of n requesters.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g, input int n);
    return (int'(g) >= n - 1) ? '0 : g + IDX_W'(1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin requester picker
// Ports:
//   req   in  NUM_REQ  pending request bits
//   ptr   in  IDX_W    first index eligible for the grant
//   valid out 1        some request bit is set
//   index out IDX_W    first set request at or after ptr, wrapping to 0
module uart_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  // Requester i sits at distance k from ptr exactly when ptr == (i - k) mod N,
  // so the right-hand side folds to a constant for every (k, i) pair.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (int'(ptr) == (i - k + NUM_REQ) % NUM_REQ)) begin
          valid = 1'b1;
          index = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding bytes to a UART transmitter
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   req, lock         per-requester byte pending / keep-grant request
//   req_data          per-requester byte, slice i = [8i+7:8i]
//   ack               one-cycle pulse, byte taken from requester i
//   txrdy             transmitter holding register free
//   tx_hold_reg       byte to the transmitter
//   tx_load           one-cycle write strobe, coincides with ack
//   grant_id          current/last granted requester
//   busy              FSM not in IDLE
//   timeout_err       one-cycle pulse when txrdy fails to return in time
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      txrdy,
  output logic [BYTE_W-1:0]         tx_hold_reg,
  output logic                      tx_load,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int LC_W = $clog2(LOCK_MAX + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [LC_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                load_q, load_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                tout_q, tout_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  logic                req_g;
  logic                lock_g;
  logic [BYTE_W-1:0]   data_g;
  logic [NUM_REQ-1:0]  ack_sel;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Per-requester views of the granted requester.
  always_comb begin
    req_g   = 1'b0;
    lock_g  = 1'b0;
    data_g  = '0;
    ack_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        req_g      = req[i];
        lock_g     = lock[i];
        data_g     = req_data[i*BYTE_W +: BYTE_W];
        ack_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    wd_d       = wd_q;
    hold_d     = hold_q;
    load_d     = 1'b0;
    ack_d      = '0;
    tout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (txrdy && pick_valid) begin
          g_d     = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A requester that withdrew between grant and load is skipped silently.
        if (req_g) begin
          hold_d     = data_g;
          load_d     = 1'b1;
          ack_d      = ack_sel;
          lock_cnt_d = lock_cnt_q + 1'b1;
          wd_d       = '0;
          state_d    = WAIT_LO;
        end else begin
          ptr_d      = next_idx(g_q, NUM_REQ);
          lock_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      WAIT_LO, WAIT_RDY: begin
        if (wd_q == WD_W'(TIMEOUT - 1)) begin
          tout_d     = 1'b1;
          ptr_d      = next_idx(g_q, NUM_REQ);
          lock_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
          if (state_q == WAIT_LO) begin
            if (!txrdy) state_d = WAIT_RDY;
          end else if (txrdy) begin
            if (lock_g && req_g && (lock_cnt_q < LC_W'(LOCK_MAX))) begin
              state_d = LOAD;
            end else begin
              ptr_d      = next_idx(g_q, NUM_REQ);
              lock_cnt_d = '0;
              state_d    = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      g_q        <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      wd_q       <= '0;
      hold_q     <= '0;
      load_q     <= 1'b0;
      ack_q      <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      wd_q       <= wd_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      ack_q      <= ack_d;
      tout_q     <= tout_d;
    end
  end

  assign ack         = ack_q;
  assign tx_hold_reg = hold_q;
  assign tx_load     = load_q;
  assign grant_id    = g_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  typedef struct {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        txrdy = 1'b1;
  logic [7:0]  tx_hold_reg;
  logic        tx_load;
  logic [2:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   sent[4];
  int   quota[4];
  logic [3:0] pulse;
  logic tx_stuck;
  int   tx_cnt = 0;
  exp_t mon_e;
  logic [3:0] mon_oh;
  int   n;
  int   s2;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .LOCK_MAX(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .lock        (lock),
    .req_data    (req_data),
    .ack         (ack),
    .txrdy       (txrdy),
    .tx_hold_reg (tx_hold_reg),
    .tx_load     (tx_load),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // A requester holds req while it still owes bytes; pulse forces a bare request.
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) req[i] = (sent[i] < quota[i]) || pulse[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] id);
    exp_t e;
    e.data = d;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic wait_load(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tx_load && cnt < 64);
    chk("load_seen", {31'd0, tx_load}, 32'd1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor, requester ack bookkeeping and transmitter model.
  initial begin
    for (int i = 0; i < 4; i++) sent[i] = 0;
    forever begin
      @(negedge clk);
      if (tx_load || ack != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", {23'd0, tx_load, ack, tx_hold_reg}, 32'd0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = 4'b0001 << mon_e.id;
          chk("byte_data", {24'd0, tx_hold_reg}, {24'd0, mon_e.data});
          chk("byte_grant", {29'd0, grant_id}, {29'd0, mon_e.id});
          chk("byte_ack", {28'd0, ack}, {28'd0, mon_oh});
          chk("byte_strobe", {31'd0, tx_load}, 32'd1);
        end
      end
      for (int i = 0; i < 4; i++) if (ack[i]) sent[i]++;
      if (tx_load) begin
        txrdy  = 1'b0;
        tx_cnt = 3;
      end else if (!tx_stuck) begin
        if (tx_cnt > 0) tx_cnt--;
        if (tx_cnt == 0) txrdy = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n  = 1'b0;
    lock     = '0;
    pulse    = '0;
    tx_stuck = 1'b0;
    req_data = 32'h1312_115A;
    for (int i = 0; i < 4; i++) quota[i] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_load", {31'd0, tx_load}, 32'd0);
    chk("rst_hold", {24'd0, tx_hold_reg}, 32'd0);
    chk("rst_grant", {29'd0, grant_id}, 32'd0);
    chk("rst_busy_tout", {30'd0, busy, timeout_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single requester: 0x5A, load two cycles after req.
    quota[0] = sent[0] + 1;
    push(8'h5A, 3'd0);
    wait_load(n);
    chk("single_latency", n, 32'd2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("single_idle_txrdy", {30'd0, busy, txrdy}, 32'd1);
    chk("single_hold_kept", {24'd0, tx_hold_reg}, 32'h5A);

    // Reset while in WAIT_RDY serving requester 1 (ptr is 1 now).
    req_data = 32'h1312_1110;
    quota[1] = sent[1] + 1;
    push(8'h11, 3'd1);
    wait_load(n);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", {17'd0, ack, tx_load, tx_hold_reg, grant_id, busy, timeout_err}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) quota[i] = sent[i] + 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 3'(i));
    @(negedge clk);
    chk("mid_rst_next", {27'd0, tx_load, ack}, 32'd0);

    // Fairness: all four pending, grants 0,1,2,3,0,1,2,3 starting after reset.
    wait_drain();

    // Lock on requester 0: three bytes, one from 1, then 0 again.
    lock = 4'b0001;
    quota[0] = sent[0] + 6;
    quota[1] = sent[1] + 1;
    for (int i = 0; i < 3; i++) push(8'h10, 3'd0);
    push(8'h11, 3'd1);
    for (int i = 0; i < 3; i++) push(8'h10, 3'd0);
    wait_drain();
    lock = 4'b0000;

    // Watchdog: transmitter never frees after the load.
    tx_stuck = 1'b1;
    quota[2] = sent[2] + 1;
    push(8'h12, 3'd2);
    wait_load(n);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 64);
    chk("timeout_latency", n, 32'd16);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("timeout_pulse_len", {31'd0, timeout_err}, 32'd0);
    // ptr must now be 3, so requester 3 beats requester 2.
    tx_stuck = 1'b0;
    quota[2] = sent[2] + 1;
    quota[3] = sent[3] + 1;
    push(8'h13, 3'd3);
    push(8'h12, 3'd2);
    wait_drain();

    // Withdrawn request: req[2] pulses once while requester 0 is served.
    quota[0] = sent[0] + 1;
    push(8'h10, 3'd0);
    wait_load(n);
    s2 = sent[2];
    @(negedge clk);
    pulse = 4'b0100;
    chk("withdraw_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    pulse = 4'b0000;
    wait_drain();
    repeat (10) @(negedge clk);
    chk("withdraw_no_ack", sent[2], s2);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
